// File: rtl/mem_burst_ctrl_if.sv
// Command, memory-port and stream signals of mem_burst_ctrl.
// slave = controller view, master = command issuer / memory / consumer view.
interface mem_burst_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [AW:0]   cmd_len;
  logic [DW-1:0] cmd_pattern;

  logic          mem_rd;
  logic [AW-1:0] mem_raddr;
  logic          mem_wr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          rs_valid;
  logic [DW-1:0] rs_data;
  logic          rs_ready;

  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern,
    input  mem_rdata, rs_ready,
    output cmd_ready, mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata,
    output rs_valid, rs_data, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_pattern,
    output mem_rdata, rs_ready,
    input  cmd_ready, mem_rd, mem_raddr, mem_wr, mem_waddr, mem_wdata,
    input  rs_valid, rs_data, busy, done, err
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst engine (FILL / COPY / STREAM) driving a 16x32 full-duplex memory port.
// Define MEM_BURST_CTRL_VERIFY_EN to add read-back verification after every write.
module mem_burst_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  mem_burst_ctrl_if.slave bus
);
  localparam logic [1:0] OP_FILL = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_STRM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL_WR, S_CPY_RD, S_CPY_WR, S_RS_RD, S_RS_CAP, S_RS_HOLD, S_DONE,
    S_VFY_RD, S_VFY_CMP
  } state_t;

  state_t        state, nxt;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] pat;
  logic [DW-1:0] rs_q;
  logic          err_q;
  logic [AW:0]   len_sat;

`ifdef MEM_BURST_CTRL_VERIFY_EN
  logic [DW-1:0] wq;
  logic [AW-1:0] vaddr;
  logic [1:0]    op_q;
`endif

  assign len_sat = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (bus.cmd_valid) begin
        if (bus.cmd_op == OP_RSVD || len_sat == '0) nxt = S_DONE;
        else if (bus.cmd_op == OP_FILL)             nxt = S_FILL_WR;
        else if (bus.cmd_op == OP_COPY)             nxt = S_CPY_RD;
        else                                        nxt = S_RS_RD;
      end
`ifdef MEM_BURST_CTRL_VERIFY_EN
      S_FILL_WR: nxt = S_VFY_RD;
      S_CPY_WR:  nxt = S_VFY_RD;
      S_VFY_RD:  nxt = S_VFY_CMP;
      S_VFY_CMP: begin
        if (cnt == '0)           nxt = S_DONE;
        else if (op_q == OP_FILL) nxt = S_FILL_WR;
        else                      nxt = S_CPY_RD;
      end
`else
      S_FILL_WR: nxt = (cnt == LEN_ONE) ? S_DONE : S_FILL_WR;
      S_CPY_WR:  nxt = (cnt == LEN_ONE) ? S_DONE : S_CPY_RD;
`endif
      S_CPY_RD:  nxt = S_CPY_WR;
      S_RS_RD:   nxt = S_RS_CAP;
      S_RS_CAP:  nxt = S_RS_HOLD;
      S_RS_HOLD: if (bus.rs_ready) nxt = (cnt == LEN_ONE) ? S_DONE : S_RS_RD;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Datapath registers; cnt counts words still to be written/delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      cnt   <= '0;
      pat   <= '0;
      rs_q  <= '0;
      err_q <= 1'b0;
`ifdef MEM_BURST_CTRL_VERIFY_EN
      wq    <= '0;
      vaddr <= '0;
      op_q  <= OP_FILL;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          rptr  <= bus.cmd_src;
          wptr  <= bus.cmd_dst;
          cnt   <= len_sat;
          pat   <= bus.cmd_pattern;
          err_q <= (bus.cmd_op == OP_RSVD);
`ifdef MEM_BURST_CTRL_VERIFY_EN
          op_q  <= bus.cmd_op;
`endif
        end
        S_FILL_WR: begin
          wptr <= wptr + 1'b1;
          cnt  <= cnt - 1'b1;
`ifdef MEM_BURST_CTRL_VERIFY_EN
          wq    <= pat;
          vaddr <= wptr;
`endif
        end
        S_CPY_WR: begin
          wptr <= wptr + 1'b1;
          rptr <= rptr + 1'b1;
          cnt  <= cnt - 1'b1;
`ifdef MEM_BURST_CTRL_VERIFY_EN
          wq    <= bus.mem_rdata;
          vaddr <= wptr;
`endif
        end
        S_RS_CAP: begin
          rs_q <= bus.mem_rdata;
          rptr <= rptr + 1'b1;
        end
        S_RS_HOLD: if (bus.rs_ready) cnt <= cnt - 1'b1;
`ifdef MEM_BURST_CTRL_VERIFY_EN
        S_VFY_CMP: if (bus.mem_rdata != wq) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Outputs; reset forces the idle values combinationally so an in-flight
  // write is dropped on the reset cycle itself.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.mem_rd    = 1'b1;
    bus.mem_raddr = '0;
    bus.mem_wr    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.rs_valid  = 1'b0;
    bus.rs_data   = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    if (!rst) begin
      bus.err       = err_q;
      bus.mem_raddr = rptr;
      case (state)
        S_IDLE: begin
          bus.cmd_ready = 1'b1;
          bus.mem_raddr = '0;
        end
        S_FILL_WR: begin
          bus.mem_rd    = 1'b0;
          bus.mem_wr    = 1'b1;
          bus.mem_waddr = wptr;
          bus.mem_wdata = pat;
          bus.busy      = 1'b1;
        end
        S_CPY_WR: begin
          bus.mem_rd    = 1'b0;
          bus.mem_wr    = 1'b1;
          bus.mem_waddr = wptr;
          bus.mem_wdata = bus.mem_rdata;
          bus.busy      = 1'b1;
        end
        S_RS_HOLD: begin
          bus.rs_valid = 1'b1;
          bus.rs_data  = rs_q;
          bus.busy     = 1'b1;
        end
`ifdef MEM_BURST_CTRL_VERIFY_EN
        S_VFY_RD: begin
          bus.mem_raddr = vaddr;
          bus.busy      = 1'b1;
        end
`endif
        S_DONE:  bus.done = 1'b1;
        default: bus.busy = 1'b1;
      endcase
    end
  end

  wire unused_op = (OP_STRM == 2'b10);
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural memory and reference model.
module tb_mem_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_ctrl_if #(.DW(16), .AW(5)) bus();
  mem_burst_ctrl #(.DW(16), .AW(5), .DEPTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory model: write, else read (registered), else zero memory[waddr].
  logic [15:0] mem [32];
  logic [15:0] dout;
  logic        pre_we = 1'b0;
  logic [4:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (rst) dout <= '0;
    else if (bus.mem_wr) mem[bus.mem_waddr] <= bus.mem_wdata;
    else if (bus.mem_rd) dout <= mem[bus.mem_raddr];
    else mem[bus.mem_waddr] <= '0;
  end
  assign bus.mem_rdata = dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [4:0] a; logic [15:0] d; } wr_t;
  typedef struct { int lat; logic err; } dn_t;
  wr_t         wq[$];
  logic [15:0] sq[$];
  dn_t         dq[$];
  logic [15:0] ref_mem [32];
  int          acc_cyc  = 0;
  bit          free_run = 1'b0;
  bit          force_low = 1'b1;

  // Monitor
  bit          hold_prev = 1'b0;
  logic [15:0] prev_d;
  wr_t         w;
  dn_t         dn;
  always @(negedge clk) begin
    if (rst) hold_prev = 1'b0;
    else begin
      chk("rd_xor_wr", {31'd0, bus.mem_rd ^ bus.mem_wr}, 1);
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (bus.mem_wr) begin
        if (wq.size() == 0) begin
          if (!free_run) chk("unexp_wr", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", {27'd0, bus.mem_waddr}, {27'd0, w.a});
          chk("wr_data", {16'd0, bus.mem_wdata}, {16'd0, w.d});
        end
      end
      if (hold_prev) begin
        chk("rs_hold_valid", {31'd0, bus.rs_valid}, 1);
        chk("rs_hold_data", {16'd0, bus.rs_data}, {16'd0, prev_d});
      end
      if (bus.rs_valid && bus.rs_ready) begin
        if (sq.size() == 0) chk("unexp_rs", 1, 0);
        else chk("rs_data", {16'd0, bus.rs_data}, {16'd0, sq.pop_front()});
      end
      hold_prev = bus.rs_valid && !bus.rs_ready;
      prev_d    = bus.rs_data;
      if (bus.done) begin
        if (dq.size() == 0) chk("unexp_done", 1, 0);
        else begin
          dn = dq.pop_front();
          if (dn.lat >= 0) chk("done_lat", cyc - acc_cyc, dn.lat);
          chk("done_err", {31'd0, bus.err}, {31'd0, dn.err});
          chk("done_busy", {31'd0, bus.busy}, 0);
        end
      end
    end
  end

  initial begin
    bus.rs_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.rs_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic preload(input logic [4:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [4:0] src, input logic [4:0] dst,
                           input logic [5:0] len, input logic [15:0] pat);
    int t;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_src = src;
    bus.cmd_dst = dst; bus.cmd_len = len; bus.cmd_pattern = pat;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.cmd_ready && t < 50);
    if (!bus.cmd_ready) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_src = 5'($urandom); bus.cmd_dst = 5'($urandom);
    bus.cmd_len = 6'($urandom); bus.cmd_pattern = 16'($urandom);
  endtask

  // Reference model: expected effects derived straight from the command semantics.
  task automatic issue(input logic [1:0] op, input logic [4:0] src, input logic [4:0] dst,
                       input logic [5:0] len, input logic [15:0] pat);
    int L, t;
    wr_t e;
    dn_t d;
    L = (len > 32) ? 32 : int'(len);
    d.err = (op == 2'b11);
    if (op == 2'b11 || L == 0) d.lat = 1;
    else if (op == 2'b00) d.lat = L + 1;
    else if (op == 2'b01) d.lat = 2 * L + 1;
    else d.lat = -1;
    if (op != 2'b11) begin
      for (int k = 0; k < L; k++) begin
        if (op == 2'b00) begin
          e.a = 5'((int'(dst) + k) % 32); e.d = pat;
          ref_mem[e.a] = pat; wq.push_back(e);
        end else if (op == 2'b01) begin
          e.a = 5'((int'(dst) + k) % 32); e.d = ref_mem[(int'(src) + k) % 32];
          ref_mem[e.a] = e.d; wq.push_back(e);
        end else sq.push_back(ref_mem[(int'(src) + k) % 32]);
      end
    end
    dq.push_back(d);
    drive_cmd(op, src, dst, len, pat);
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.done) break;
      if (++t > 3000) begin chk("done_timeout", 1, 0); break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_src = '0; bus.cmd_dst = '0;
    bus.cmd_len = '0; bus.cmd_pattern = '0;
    for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));
    preload(5'd0, 16'hBEEF);
    preload(5'd2, 16'h1234);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 0);
    chk("rst_rd", {31'd0, bus.mem_rd}, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, bus.cmd_ready}, 1);
      chk("idle_rd", {31'd0, bus.mem_rd}, 1);
      chk("idle_wr", {31'd0, bus.mem_wr}, 0);
      chk("idle_raddr", {27'd0, bus.mem_raddr}, 0);
      chk("idle_flags", {28'd0, bus.busy, bus.done, bus.err, bus.rs_valid}, 0);
      chk("idle_rsdata", {16'd0, bus.rs_data}, 0);
    end
    chk("idle_mem0", {16'd0, mem[0]}, 32'hBEEF);

    issue(2'b00, 5'd0, 5'd30, 6'd4, 16'hA5A5);
    chk("fill_addr2", {16'd0, mem[2]}, 32'h1234);

    for (int i = 0; i < 4; i++) preload(5'(i), 16'(i + 1));
    issue(2'b01, 5'd0, 5'd8, 6'd4, 16'h0);
    for (int i = 0; i < 4; i++) chk("copy_dst", {16'd0, mem[8 + i]}, i + 1);

    force_low = 1'b1;
    fork
      issue(2'b10, 5'd0, 5'd0, 6'd3, 16'h0);
      begin
        t = 0;
        while (!bus.rs_valid && t < 100) begin @(negedge clk); t++; end
        chk("rs_seen", {31'd0, bus.rs_valid}, 1);
        repeat (4) begin
          chk("rs_w0_valid", {31'd0, bus.rs_valid}, 1);
          chk("rs_w0_data", {16'd0, bus.rs_data}, 32'h0001);
          @(negedge clk);
        end
        force_low = 1'b0;
      end
    join

    // Reset in the middle of a 32-word FILL: 9 writes land, the 10th is dropped.
    free_run = 1'b1;
    drive_cmd(2'b00, 5'd0, 5'd12, 6'd32, 16'h5A5A);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_wr", {31'd0, bus.mem_wr}, 0);
    chk("mrst_ready", {31'd0, bus.cmd_ready}, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 9; k++) ref_mem[(12 + k) % 32] = 16'h5A5A;
    free_run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_busy", {31'd0, bus.busy}, 0);
      chk("mrst_ready_idle", {31'd0, bus.cmd_ready}, 1);
    end
    issue(2'b00, 5'd0, 5'd4, 6'd0, 16'hFFFF);

    issue(2'b11, 5'd1, 5'd2, 6'd5, 16'h0);
    @(negedge clk);
    chk("err_sticky", {31'd0, bus.err}, 1);
    issue(2'b00, 5'd0, 5'd20, 6'd2, 16'h3C3C);

    for (int n = 0; n < 40; n++)
      issue(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            5'($urandom), 5'($urandom), 6'($urandom_range(0, 40)), 16'($urandom));

    repeat (3) @(negedge clk);
    for (int i = 0; i < 32; i++) chk("final_mem", {16'd0, mem[i]}, {16'd0, ref_mem[i]});
    chk("q_empty", wq.size() + sq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
- Initiator-side engine for the 16x32 full-duplex memory port (rd/raddr, wr/waddr, d_in, registered d_out).
- Accepts one command at a time over a valid/ready interface and executes FILL (write a pattern), COPY (memory-to-memory) or STREAM (memory-to-consumer) bursts.
- Drives the memory's ports directly.
- The memory zeroes memory[waddr] on any non-reset cycle with rd=0 and wr=0. This block therefore never presents rd=0 together with wr=0 outside reset.

Parameters:
- DW, 16, data width.
- AW, 5, address width.
- DEPTH, 32, words in the target memory (2**AW).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  00=FILL, 01=COPY, 10=STREAM, 11=reserved.
- cmd_src  in  AW  start read address (COPY, STREAM).
- cmd_dst  in  AW  start write address (FILL, COPY).
- cmd_len  in  AW+1  word count.
- cmd_pattern  in  DW  FILL data.
- mem_rd  out  1  to memory rd.
- mem_raddr  out  AW  to memory raddr.
- mem_wr  out  1  to memory wr.
- mem_waddr  out  AW  to memory waddr.
- mem_wdata  out  DW  to memory d_in.
- mem_rdata  in  DW  from memory d_out.
- rs_valid  out  1  stream word valid.
- rs_data  out  DW  stream word.
- rs_ready  in  1  consumer accepts stream word.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky error flag; cleared on the next accepted command.

Behaviour:
- Reset/IDLE outputs:
  - cmd_ready=1 (0 while rst=1), mem_rd=1, mem_raddr=0, mem_wr=0, mem_waddr=0, mem_wdata=0.
  - rs_valid=0, rs_data=0, busy=0, done=0, err=0.
- Keep-alive: in IDLE and every state with no write, mem_rd=1 at the current read pointer.
- Accept: a command is taken on the edge where cmd_valid && cmd_ready. busy goes high the next cycle.
- Length rules:
  - cmd_len=0: no memory access; done pulses the cycle after accept.
  - cmd_len>DEPTH: saturates to DEPTH.
- Pointers increment modulo DEPTH (31 wraps to 0).
- FILL:
  - State FILL_WR, one word per cycle: mem_wr=1, mem_waddr=dst+k, mem_wdata=cmd_pattern (latched at accept).
  - Exactly len write cycles, starting the cycle after accept.
- COPY:
  - CPY_RD (mem_rd=1, raddr=src+k), then CPY_WR (mem_wr=1, waddr=dst+k, mem_wdata=mem_rdata).
  - 2*len cycles, ascending order.
  - Overlapping regions copy forward word-by-word, with no overlap protection.
- STREAM:
  - RS_RD issues the read. RS_CAP captures mem_rdata into rs_data and sets rs_valid=1.
  - RS_HOLD holds rs_data/rs_valid stable until rs_ready; the handshake completes on rs_valid && rs_ready.
  - After the handshake: next word goes to RS_RD; otherwise finish.
  - Keep-alive reads in RS_HOLD may change mem_rdata; rs_data must not change.
- DONE: done=1 for one cycle, busy=0, then IDLE. cmd_ready returns high the cycle after done.
- cmd_op=11: no memory access; err=1 and done pulse the cycle after accept.
- States: IDLE, FILL_WR, CPY_RD, CPY_WR, RS_RD, RS_CAP, RS_HOLD, DONE (plus VFY_RD and VFY_CMP when the feature is enabled).
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - No done pulse; the partial burst is abandoned.
- mem_rd and mem_wr are never both 1. A write cycle always has mem_rd=0.

Optional Feature:
- Macro: MEM_BURST_CTRL_VERIFY_EN.
- Defined:
  - Each FILL or COPY write is followed by VFY_RD (mem_rd=1, raddr=just-written address), then VFY_CMP.
  - VFY_CMP compares mem_rdata with the written word. A mismatch sets err, and the burst continues.
  - Cycle cost: FILL 3 per word, COPY 4 per word.
- Undefined: no verify states; err is set only by cmd_op=11.

Test Plan:
- Reset, then idle 5 cycles -> mem_rd=1 and mem_wr=0 every cycle; no memory word changes (addr 0 preloaded 0xBEEF stays 0xBEEF).
- FILL dst=30, len=4, pattern=0xA5A5 -> writes addresses 30, 31, 0, 1 on 4 consecutive cycles; done 1 cycle after the last write; address 2 unchanged.
- Preload addr 0..3 = 0x0001..0x0004; COPY src=0, dst=8, len=4 -> addr 8..11 = 0x0001..0x0004; 8 active cycles, then done.
- STREAM src=0, len=3, rs_ready held low 4 cycles on word 0 -> rs_data stays 0x0001 with rs_valid=1; then 0x0001, 0x0002, 0x0003 delivered in order; done after the third handshake.
- FILL len=32 with rst asserted at write 10 -> next cycle IDLE, busy=0, no done pulse; new FILL len=0 accepted -> done pulse, no writes.
- cmd_op=11 -> err=1 and done pulse; next valid FILL accepted -> err clears.
